// File: rtl/mips_cpu_bus_bridge.sv
// Serialises the Harvard CPU's instr/data ports onto one word-addressed bus; one cpu_clk_enable pulse per instruction.
// Latency 3 cycles/instruction plus 1 per waitrequest cycle; holds requests under waitrequest, halts after WAIT_LIMIT stalls.
module mips_cpu_bus_bridge #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error,
  output logic        halted
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {FETCH, DATA, COMMIT, HALT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   r_instr;
  logic [31:0]   r_data;
  logic          r_bus_error;
  logic          w_read;
  logic          w_write;
  logic [31:0]   w_addr;
  logic          w_set_err;
  logic          w_unused;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_write     = 1'b0;
    w_addr      = 32'h0;
    w_set_err   = 1'b0;
    case (r_state)
      FETCH: begin
        if (!cpu_active) begin
          w_state_nxt = HALT;
        end else begin
          w_read = 1'b1;
          w_addr = {cpu_instr_address[31:2], 2'b00};
        end
      end
      DATA: begin
        // a store and a load together is a CPU fault: the store goes out, the error is recorded
        w_write   = cpu_data_write;
        w_read    = cpu_data_read & ~cpu_data_write;
        w_addr    = {cpu_data_address[31:2], 2'b00};
        w_set_err = cpu_data_read & cpu_data_write;
        if (!(w_read | w_write)) w_state_nxt = COMMIT;
      end
      COMMIT:  w_state_nxt = FETCH;
      default: w_state_nxt = HALT;
    endcase
    if (w_read | w_write) begin
      if (!waitrequest) begin
        w_state_nxt = (r_state == FETCH) ? DATA : COMMIT;
      end else if (r_wait_cnt == CW'(WAIT_LIMIT - 1)) begin
        // this is the last stall we tolerate; request is gone next cycle
        w_state_nxt = HALT;
        w_set_err   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr     <= 32'h0;
      r_data      <= 32'h0;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (r_state == FETCH && w_read && !waitrequest) r_instr <= readdata;
      if (r_state == DATA && w_read && !waitrequest)  r_data  <= readdata;
      if (w_set_err) r_bus_error <= 1'b1;
      if (w_state_nxt != r_state)            r_wait_cnt <= '0;
      else if ((w_read | w_write) && waitrequest) r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  assign read               = w_read & ~reset;
  assign write              = w_write & ~reset;
  assign address            = reset ? 32'h0 : w_addr;
  assign writedata          = (r_state == DATA && !reset) ? cpu_data_writedata : 32'h0;
  assign byteenable         = (read | write) ? 4'hF : 4'h0;
  assign cpu_clk_enable     = (r_state == COMMIT) & ~reset;
  assign halted             = (r_state == HALT) & ~reset;
  assign bus_error          = r_bus_error & ~reset;
  assign cpu_instr_readdata = r_instr;
  assign cpu_data_readdata  = r_data;

  assign w_unused = ^{cpu_instr_address[1:0], cpu_data_address[1:0]};

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// Bench for mips_cpu_bus_bridge: per-cycle expected bus trace expanded from instruction descriptions.
module tb_mips_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;
  logic        halted;

  mips_cpu_bus_bridge #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .cpu_clk_enable(cpu_clk_enable), .cpu_active(cpu_active),
    .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .bus_error(bus_error), .halted(halted)
  );

  always #5 clk = ~clk;

  // one entry per clock cycle: what the CPU/memory drive, and what the bus must show
  typedef struct {
    logic        rst, act, dr, dw, wq;
    logic [31:0] ia, da, wd, rdat;
    logic        e_rd, e_wr, e_ce, e_halt, e_berr, lat;
    logic [31:0] e_addr, e_wd, e_instr, e_data;
  } step_t;

  step_t       q[$];
  step_t       cur;
  bit          cur_vld = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc, rd_cnt, wr_cnt, ce_cnt, last_ce;
  bit          m_berr, m_halt;
  logic [31:0] m_last_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (cur_vld) begin
      cyc++;
      chk1("read", read, cur.e_rd);
      chk1("write", write, cur.e_wr);
      chk1("cpu_clk_enable", cpu_clk_enable, cur.e_ce);
      chk1("halted", halted, cur.e_halt);
      chk1("bus_error", bus_error, cur.e_berr);
      chk("byteenable", 32'(byteenable), (cur.e_rd | cur.e_wr) ? 32'hF : 32'h0);
      if (cur.e_rd | cur.e_wr) chk("address", address, cur.e_addr);
      if (cur.e_wr) chk("writedata", writedata, cur.e_wd);
      if (cur.lat) begin
        chk("cpu_instr_readdata", cpu_instr_readdata, cur.e_instr);
        chk("cpu_data_readdata", cpu_data_readdata, cur.e_data);
      end
      if (read === 1'b1) rd_cnt++;
      if (write === 1'b1) wr_cnt++;
      if (cpu_clk_enable === 1'b1) begin
        ce_cnt++;
        last_ce = cyc;
      end
    end
  end

  function automatic step_t mk();
    step_t s;
    s = '{default: '0};
    s.act    = 1'b1;
    s.wq     = 1'($urandom);
    s.rdat   = $urandom;
    s.ia     = $urandom;
    s.da     = $urandom;
    s.wd     = $urandom;
    s.e_berr = m_berr;
    s.e_halt = m_halt;
    return s;
  endfunction

  task automatic clear_cnt();
    cyc = 0; rd_cnt = 0; wr_cnt = 0; ce_cnt = 0; last_ce = 0;
  endtask

  task automatic gen_reset(input int n);
    step_t s;
    m_berr = 0; m_halt = 0; m_last_load = 32'h0;
    for (int i = 0; i < n; i++) begin
      s = mk();
      s.rst = 1'b1;
      s.act = 1'($urandom);
      s.lat = (i > 0);
      q.push_back(s);
    end
  endtask

  // kind: 0 no memory op, 1 load, 2 store, 3 both strobes; trunc >= 0 cuts the data phase short
  task automatic gen_instr(input logic [31:0] ia, input logic [1:0] kind, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] iword, input int fw,
                           input int dw, input logic [31:0] rdat, input int trunc);
    step_t s;
    logic  jr, jw;
    jr = 1'($urandom);
    jw = 1'($urandom);
    for (int j = 0; j <= fw; j++) begin
      s = mk();
      s.ia = ia; s.da = da; s.wd = wd; s.dr = jr; s.dw = jw;
      s.wq = (j < fw);
      if (j == fw) s.rdat = iword;
      s.e_rd = 1'b1;
      s.e_addr = {ia[31:2], 2'b00};
      q.push_back(s);
    end
    if (kind == 2'd0) begin
      s = mk();
      s.ia = ia; s.da = da; s.wd = wd;
      q.push_back(s);
    end else begin
      for (int j = 0; j <= dw; j++) begin
        if (trunc >= 0 && j >= trunc) return;
        s = mk();
        s.ia = ia; s.da = da; s.wd = wd; s.dr = kind[0]; s.dw = kind[1];
        s.wq = (j < dw);
        if (j == dw) s.rdat = rdat;
        s.e_wr = kind[1];
        s.e_rd = kind[0] & ~kind[1];
        s.e_addr = {da[31:2], 2'b00};
        s.e_wd = wd;
        q.push_back(s);
        if (kind == 2'd3) m_berr = 1;
        if (kind == 2'd1 && j == dw) m_last_load = rdat;
      end
    end
    s = mk();
    s.ia = ia; s.da = da; s.wd = wd; s.dr = kind[0]; s.dw = kind[1];
    s.e_ce = 1'b1;
    s.lat = 1'b1;
    s.e_instr = iword;
    s.e_data = m_last_load;
    q.push_back(s);
  endtask

  task automatic gen_halt(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = mk();
      s.act = 1'($urandom);
      q.push_back(s);
    end
  endtask

  task automatic gen_timeout(input logic [31:0] ia);
    step_t s;
    for (int j = 0; j < 16; j++) begin
      s = mk();
      s.ia = ia;
      s.wq = 1'b1;
      s.e_rd = 1'b1;
      s.e_addr = {ia[31:2], 2'b00};
      q.push_back(s);
    end
    m_berr = 1; m_halt = 1;
    gen_halt(6);
  endtask

  task automatic gen_inactive();
    step_t s;
    s = mk();
    s.act = 1'b0;
    q.push_back(s);
    m_halt = 1;
    gen_halt(4);
  endtask

  task automatic run_all();
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      cur = q.pop_front();
      reset              = cur.rst;
      cpu_active         = cur.act;
      cpu_instr_address  = cur.ia;
      cpu_data_address   = cur.da;
      cpu_data_read      = cur.dr;
      cpu_data_write     = cur.dw;
      cpu_data_writedata = cur.wd;
      waitrequest        = cur.wq;
      readdata           = cur.rdat;
      cur_vld            = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] kind;
    int         r;
    reset = 1'b1; cpu_active = 1'b0; cpu_instr_address = 32'h0; cpu_data_address = 32'h0;
    cpu_data_read = 1'b0; cpu_data_write = 1'b0; cpu_data_writedata = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    clear_cnt();

    gen_reset(2);
    run_all();

    clear_cnt();
    gen_instr(32'hBFC00000, 2'd0, 32'h100, 32'h0, 32'h24020005, 0, 0, 32'h0, -1);
    run_all();
    chk("t1 ce count", ce_cnt, 1);
    chk("t1 ce cycle", last_ce, 3);
    chk("t1 read cycles", rd_cnt, 1);
    chk("t1 instr latch", cpu_instr_readdata, 32'h24020005);

    clear_cnt();
    gen_instr(32'hBFC00004, 2'd1, 32'h00001004, $urandom, 32'h8C220004, 0, 2, 32'hDEADBEEF, -1);
    run_all();
    chk("t2 instr cycles", last_ce, 5);
    chk("t2 read cycles", rd_cnt, 4);
    chk("t2 load latch", cpu_data_readdata, 32'hDEADBEEF);

    clear_cnt();
    gen_instr(32'hBFC00008, 2'd2, 32'h00001006, 32'h12345678, 32'hAC230006, 0, 0, $urandom, -1);
    run_all();
    chk("t3 instr cycles", last_ce, 3);
    chk("t3 write cycles", wr_cnt, 1);
    chk("t3 read cycles", rd_cnt, 1);
    chk("t3 load kept", cpu_data_readdata, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      kind = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      gen_instr($urandom, kind, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, -1);
    end
    run_all();

    gen_instr($urandom, 2'd1, $urandom, $urandom, $urandom, 0, 10, $urandom, 3);
    gen_reset(2);
    run_all();
    clear_cnt();
    gen_instr(32'hBFC00000, 2'd0, 32'h0, 32'h0, 32'h24020005, 0, 0, 32'h0, -1);
    run_all();
    chk("t6 refetch cycles", last_ce, 3);
    chk("t6 refetch instr", cpu_instr_readdata, 32'h24020005);

    clear_cnt();
    gen_timeout(32'hBFC00004);
    run_all();
    chk("t4 stalled reads", rd_cnt, 16);
    chk1("t4 halted", halted, 1'b1);
    chk1("t4 bus_error", bus_error, 1'b1);

    gen_reset(2);
    run_all();
    clear_cnt();
    gen_inactive();
    run_all();
    chk("t5 reads", rd_cnt, 0);
    chk("t5 ce count", ce_cnt, 0);
    chk1("t5 halted", halted, 1'b1);
    chk1("t5 bus_error", bus_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
